// File: rtl/axis_sweep_pkg.sv
// Shared definitions for the frame-length sweep controller: default widths and FSM encoding.
package axis_sweep_pkg;

  localparam int unsigned LEN_WIDTH_DEF = 11;
  localparam int unsigned CNT_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } sweep_state_t;

endpackage

// File: rtl/axis_len_sweep_ctrl_if.sv
// Length-command streams to generator/DMA plus the monitor tap on the generator output.
interface axis_len_sweep_if #(
  parameter int unsigned LEN_WIDTH = axis_sweep_pkg::LEN_WIDTH_DEF
);
  logic [LEN_WIDTH-1:0] gen_len_tdata;
  logic                 gen_len_tvalid;
  logic                 gen_len_tready;
  logic [LEN_WIDTH-1:0] dma_len_tdata;
  logic                 dma_len_tvalid;
  logic                 dma_len_tready;
  logic                 mon_tvalid;
  logic                 mon_tready;
  logic                 mon_tlast;

  modport master (
    output gen_len_tdata, gen_len_tvalid,
    input  gen_len_tready,
    output dma_len_tdata, dma_len_tvalid,
    input  dma_len_tready,
    input  mon_tvalid, mon_tready, mon_tlast
  );

  modport slave (
    input  gen_len_tdata, gen_len_tvalid,
    output gen_len_tready,
    input  dma_len_tdata, dma_len_tvalid,
    output dma_len_tready,
    output mon_tvalid, mon_tready, mon_tlast
  );
endinterface

// File: rtl/sweep_len_step.sv
// Next sweep length: cur + step, wrapping to min when the sum overflows or exceeds max.
module sweep_len_step #(
  parameter int unsigned LEN_WIDTH = axis_sweep_pkg::LEN_WIDTH_DEF
) (
  input  logic [LEN_WIDTH-1:0] cur_len,
  input  logic [LEN_WIDTH-1:0] step,
  input  logic [LEN_WIDTH-1:0] len_min,
  input  logic [LEN_WIDTH-1:0] len_max,
  output logic [LEN_WIDTH-1:0] next_len_c
);

  logic [LEN_WIDTH:0] sum;

  // Extra bit makes carry-out compare greater than any max
  always_comb begin
    sum        = {1'b0, cur_len} + {1'b0, step};
    next_len_c = (sum > {1'b0, len_max}) ? len_min : sum[LEN_WIDTH-1:0];
  end

endmodule

// File: rtl/axis_len_sweep_ctrl.sv
// Sweeps frame lengths across [min,max], issuing each length to the generator and DMA
// and waiting for the generated frame's tlast before moving to the next length.
module axis_len_sweep_ctrl
  import axis_sweep_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = LEN_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LEN_WIDTH-1:0] cfg_len_min,
  input  logic [LEN_WIDTH-1:0] cfg_len_max,
  input  logic [LEN_WIDTH-1:0] cfg_len_step,
  input  logic [CNT_WIDTH-1:0] cfg_frame_count,
  axis_len_sweep_if.master     bus,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic [CNT_WIDTH-1:0] frames_done
);

  sweep_state_t         state;
  logic [LEN_WIDTH-1:0] len_min;
  logic [LEN_WIDTH-1:0] len_max;
  logic [LEN_WIDTH-1:0] len_step;
  logic [CNT_WIDTH-1:0] frame_count;
  logic [LEN_WIDTH-1:0] cur_len;
  logic [LEN_WIDTH-1:0] next_len_c;
  logic                 abort_pend;
  logic                 gen_tvalid;
  logic [LEN_WIDTH-1:0] gen_tdata;
  logic                 dma_tvalid;
  logic [LEN_WIDTH-1:0] dma_tdata;

  logic cfg_ok_c;
  logic gen_hs_c;
  logic dma_hs_c;
  logic last_hs_c;
  logic stop_c;

  assign bus.gen_len_tvalid = gen_tvalid;
  assign bus.gen_len_tdata  = gen_tdata;
  assign bus.dma_len_tvalid = dma_tvalid;
  assign bus.dma_len_tdata  = dma_tdata;

  assign cfg_ok_c  = (cfg_len_min != '0) && (cfg_len_min <= cfg_len_max);
  assign gen_hs_c  = gen_tvalid & bus.gen_len_tready;
  assign dma_hs_c  = dma_tvalid & bus.dma_len_tready;
  assign last_hs_c = bus.mon_tvalid & bus.mon_tready & bus.mon_tlast;
  // An abort arriving in NEXT itself also ends the sweep
  assign stop_c    = abort_pend | abort |
                     ((frame_count != '0) && (frames_done == frame_count));

  sweep_len_step #(.LEN_WIDTH(LEN_WIDTH)) u_step (
    .cur_len    (cur_len),
    .step       (len_step),
    .len_min    (len_min),
    .len_max    (len_max),
    .next_len_c (next_len_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      len_min     <= '0;
      len_max     <= '0;
      len_step    <= '0;
      frame_count <= '0;
      cur_len     <= '0;
      abort_pend  <= 1'b0;
      gen_tvalid  <= 1'b0;
      gen_tdata   <= '0;
      dma_tvalid  <= 1'b0;
      dma_tdata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      frames_done <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok_c) begin
              len_min     <= cfg_len_min;
              len_max     <= cfg_len_max;
              len_step    <= cfg_len_step;
              frame_count <= cfg_frame_count;
              cur_len     <= cfg_len_min;
              frames_done <= '0;
              abort_pend  <= 1'b0;
              gen_tvalid  <= 1'b1;
              gen_tdata   <= cfg_len_min;
              dma_tvalid  <= 1'b1;
              dma_tdata   <= cfg_len_min;
              busy        <= 1'b1;
              state       <= ST_ISSUE;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (abort) abort_pend <= 1'b1;
          if (gen_hs_c) gen_tvalid <= 1'b0;
          if (dma_hs_c) dma_tvalid <= 1'b0;
          if ((gen_hs_c || !gen_tvalid) && (dma_hs_c || !dma_tvalid)) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (abort) abort_pend <= 1'b1;
          if (last_hs_c) begin
            if (frames_done != '1) frames_done <= frames_done + CNT_WIDTH'(1);
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (abort) abort_pend <= 1'b1;
          if (stop_c) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cur_len    <= next_len_c;
            gen_tvalid <= 1'b1;
            gen_tdata  <= next_len_c;
            dma_tvalid <= 1'b1;
            dma_tdata  <= next_len_c;
            state      <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy       <= 1'b0;
          gen_tvalid <= 1'b0;
          dma_tvalid <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_len_sweep_ctrl.sv
// Self-checking bench for axis_len_sweep_ctrl: directed vector table, hand-written
// backpressure/reset sequences, and randomized sweeps against an arithmetic length model.
module tb_axis_len_sweep_ctrl;

  typedef struct packed {
    int mn; int mx; int st; int cnt; int abort_frame;
    int exp_err; int exp_frames;
    int l0; int l1; int l2; int l3;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [10:0] cfg_len_min, cfg_len_max, cfg_len_step;
  logic [15:0] cfg_frame_count;
  logic        busy, done, cfg_err;
  logic [15:0] frames_done;

  axis_len_sweep_if #(.LEN_WIDTH(11)) bus_if ();

  axis_len_sweep_ctrl #(.LEN_WIDTH(11), .CNT_WIDTH(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .cfg_len_min     (cfg_len_min),
    .cfg_len_max     (cfg_len_max),
    .cfg_len_step    (cfg_len_step),
    .cfg_frame_count (cfg_frame_count),
    .bus             (bus_if),
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err),
    .frames_done     (frames_done)
  );

  always #5 clk = ~clk;

  logic        gv, dv;
  logic [10:0] gd, dd;
  assign gv = bus_if.gen_len_tvalid;
  assign dv = bus_if.dma_len_tvalid;
  assign gd = bus_if.gen_len_tdata;
  assign dd = bus_if.dma_len_tdata;

  int checks = 0;
  int failures = 0;
  int got_gen[$];
  int got_dma[$];
  int exp_q[$];
  int n_err, n_done, viol;
  bit timed_out;
  vec_t tbl[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic int model_len(input int mn, input int mx, input int st, input int k);
    int c = mn;
    for (int j = 0; j < k; j++) c = (c + st > mx) ? mn : c + st;
    return c;
  endfunction

  function automatic int tbl_len(input vec_t v, input int k);
    case (k)
      0:       return v.l0;
      1:       return v.l1;
      2:       return v.l2;
      default: return v.l3;
    endcase
  endfunction

  task automatic set_mon(input bit tv, input bit tr, input bit tl);
    bus_if.mon_tvalid = tv;
    bus_if.mon_tready = tr;
    bus_if.mon_tlast  = tl;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Acts as generator + DMA + monitor; records accepted descriptors and protocol violations
  task automatic run_sweep(input vec_t v, input bit rnd);
    int  frames_sent = 0;
    int  beats_left = 0;
    int  cyc = 0;
    int  post = 0;
    int  last_tl = -10;
    bit  aborted = 0;
    bit  frame_ready, tl_hs, ghs, dhs;
    bit  prev_gv = 0, prev_dv = 0, prev_ghs = 0, prev_dhs = 0;
    logic [10:0] prev_gd = '0, prev_dd = '0;
    got_gen.delete();
    got_dma.delete();
    n_err = 0; n_done = 0; viol = 0; timed_out = 0;
    cfg_len_min     = 11'(v.mn);
    cfg_len_max     = 11'(v.mx);
    cfg_len_step    = 11'(v.st);
    cfg_frame_count = 16'(v.cnt);
    start = 1'b1;
    abort = (v.abort_frame == 0);
    bus_if.gen_len_tready = 1'b1;
    bus_if.dma_len_tready = 1'b1;
    set_mon(0, 0, 0);
    step();
    start = 1'b0;
    abort = 1'b0;
    forever begin
      if (v.exp_err != 0) begin
        if (busy || gv || dv) viol++;
      end else if (n_done == 0) begin
        if (!busy) viol++;
      end else if (!done && (busy || gv || dv)) viol++;
      if (cfg_err) n_err++;
      if (done) n_done++;
      if (cyc == 0 && v.exp_err == 0 && !(gv && dv && int'(gd) == v.mn && int'(dd) == v.mn)) viol++;
      if (cyc == last_tl + 1) begin
        if (frames_sent < v.exp_frames) begin
          if (!(gv && dv)) viol++;
        end else if (!done) viol++;
      end
      if (prev_gv && !prev_ghs && (!gv || gd != prev_gd)) viol++;
      if (prev_dv && !prev_dhs && (!dv || dd != prev_dd)) viol++;
      if (n_done > 0 || v.exp_err != 0) post++;
      if (post > 4) break;
      if (cyc >= 3000) begin
        timed_out = 1;
        break;
      end
      frame_ready = (got_gen.size() == frames_sent + 1) && (got_dma.size() == frames_sent + 1);
      bus_if.gen_len_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus_if.dma_len_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (frame_ready) begin
        if (beats_left == 0) beats_left = int'($urandom_range(1, 4));
        set_mon(rnd ? 1'($urandom_range(0, 1)) : 1'b1,
                rnd ? 1'($urandom_range(0, 1)) : 1'b1, beats_left == 1);
        if (v.abort_frame == frames_sent + 1 && !aborted) begin
          abort = 1'b1;
          aborted = 1;
        end
        if (rnd && $urandom_range(0, 5) == 0) start = 1'b1;
      end else begin
        set_mon(rnd && $urandom_range(0, 1) == 1, 1'b1, $urandom_range(0, 1) == 1);
      end
      if (rnd) begin
        cfg_len_min     = 11'($urandom);
        cfg_len_max     = 11'($urandom);
        cfg_len_step    = 11'($urandom);
        cfg_frame_count = 16'($urandom_range(0, 3));
      end
      ghs = gv && bus_if.gen_len_tready;
      dhs = dv && bus_if.dma_len_tready;
      if (ghs) got_gen.push_back(int'(gd));
      if (dhs) got_dma.push_back(int'(dd));
      tl_hs = frame_ready && bus_if.mon_tvalid && bus_if.mon_tready && bus_if.mon_tlast;
      if (frame_ready && bus_if.mon_tvalid && bus_if.mon_tready) beats_left--;
      prev_gv = gv; prev_dv = dv; prev_ghs = ghs; prev_dhs = dhs;
      prev_gd = gd; prev_dd = dd;
      step();
      start = 1'b0;
      abort = 1'b0;
      cyc++;
      if (tl_hs) begin
        frames_sent++;
        last_tl = cyc;
      end
    end
    set_mon(0, 0, 0);
  endtask

  task automatic check_run(input string tag, input vec_t v);
    check({tag, "_cfg_err"}, n_err, v.exp_err);
    check({tag, "_done_pulses"}, n_done, (v.exp_err != 0) ? 0 : 1);
    check({tag, "_frames_done"}, int'(frames_done), v.exp_frames);
    check({tag, "_gen_count"}, got_gen.size(), exp_q.size());
    check({tag, "_dma_count"}, got_dma.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_gen.size(); k++)
      check($sformatf("%s_gen_len%0d", tag, k), got_gen[k], exp_q[k]);
    for (int k = 0; k < exp_q.size() && k < got_dma.size(); k++)
      check($sformatf("%s_dma_len%0d", tag, k), got_dma[k], exp_q[k]);
    check({tag, "_protocol"}, viol, 0);
    check({tag, "_timeout"}, int'(timed_out), 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_len_min = '0; cfg_len_max = '0; cfg_len_step = '0; cfg_frame_count = '0;
    bus_if.gen_len_tready = 1'b0;
    bus_if.dma_len_tready = 1'b0;
    set_mon(0, 0, 0);
    repeat (3) step();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_frames_done", int'(frames_done), 0);
    check("rst_gen_tvalid", int'(gv), 0);
    check("rst_dma_tvalid", int'(dv), 0);
    check("rst_gen_tdata", int'(gd), 0);
    rst_n = 1'b1;
    step();

    //         mn    mx    st    cnt ab  err frm  l0    l1    l2    l3
    tbl[0] = '{64,   128,  32,   4,  -1, 0,  4,   64,   96,   128,  64};
    tbl[1] = '{1024, 2047, 1500, 2,  -1, 0,  2,   1024, 1024, 0,    0};
    tbl[2] = '{0,    100,  1,    1,  -1, 1,  0,   0,    0,    0,    0};
    tbl[3] = '{200,  100,  1,    1,  -1, 1,  0,   0,    0,    0,    0};
    tbl[4] = '{50,   50,   7,    3,  -1, 0,  3,   50,   50,   50,   0};
    tbl[5] = '{10,   200,  0,    3,  -1, 0,  3,   10,   10,   10,   0};
    tbl[6] = '{100,  400,  100,  0,  3,  0,  3,   100,  200,  300,  0};
    tbl[7] = '{64,   128,  32,   2,  0,  0,  2,   64,   96,   0,    0};
    for (int i = 0; i < 8; i++) begin
      exp_q.delete();
      for (int k = 0; k < tbl[i].exp_frames; k++) exp_q.push_back(tbl_len(tbl[i], k));
      run_sweep(tbl[i], 1'b0);
      check_run($sformatf("tbl%0d", i), tbl[i]);
      reset_pulse();
    end

    // DMA backpressure: gen accepts at once, DMA stalls 5 cycles, stray tlasts meanwhile
    cfg_len_min = 11'd64; cfg_len_max = 11'd128; cfg_len_step = 11'd32; cfg_frame_count = 16'd1;
    bus_if.gen_len_tready = 1'b1;
    bus_if.dma_len_tready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("bp_first_valid", int'({gv, dv}), 3);
    set_mon(1, 1, 1);
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_gen_low%0d", i), int'(gv), 0);
      check($sformatf("bp_dma_hold%0d", i), int'({dv, dd}), 2048 + 64);
      check($sformatf("bp_frames%0d", i), int'(frames_done), 0);
      step();
    end
    set_mon(0, 0, 0);
    bus_if.dma_len_tready = 1'b1;
    step();
    check("bp_dma_accepted", int'(dv), 0);
    bus_if.dma_len_tready = 1'b0;
    set_mon(1, 1, 1);
    step();
    set_mon(0, 0, 0);
    check("bp_frame_counted", int'(frames_done), 1);
    step();
    check("bp_done", int'({done, busy}), 3);
    step();
    check("bp_idle", int'({done, busy, gv, dv}), 0);
    check("bp_frames_hold", int'(frames_done), 1);
    reset_pulse();

    // Reset asserted while descriptors are pending
    cfg_len_min = 11'd100; cfg_len_max = 11'd300; cfg_len_step = 11'd50; cfg_frame_count = 16'd3;
    bus_if.gen_len_tready = 1'b0;
    bus_if.dma_len_tready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("rstmid_valid_before", int'({gv, dv, busy}), 7);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_valid", int'({gv, dv}), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_tdata", int'(gd), 0);
    check("rstmid_frames", int'(frames_done), 0);
    step();
    rst_n = 1'b1;
    bus_if.gen_len_tready = 1'b1;
    bus_if.dma_len_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rstmid_quiet%0d", i), int'({gv, dv, busy}), 0);
    end

    // Randomized sweeps with random backpressure, cfg churn and ignored start pulses
    for (int r = 0; r < 24; r++) begin
      vec_t v;
      v = '0;
      if ($urandom_range(0, 4) == 0) begin
        v.mn = int'($urandom_range(0, 2047));
        v.mx = int'($urandom_range(0, 2047));
      end else begin
        v.mn = int'($urandom_range(1, 2047));
        v.mx = int'($urandom_range(v.mn, 2047));
      end
      case ($urandom_range(0, 3))
        0:       v.st = 0;
        1:       v.st = int'($urandom_range(1, 64));
        default: v.st = int'($urandom_range(0, 2047));
      endcase
      v.cnt = int'($urandom_range(0, 6));
      if (v.cnt == 0) v.abort_frame = int'($urandom_range(1, 5));
      else begin
        case ($urandom_range(0, 2))
          0:       v.abort_frame = -1;
          1:       v.abort_frame = 0;
          default: v.abort_frame = int'($urandom_range(1, v.cnt + 1));
        endcase
      end
      v.exp_err = (v.mn == 0 || v.mn > v.mx) ? 1 : 0;
      if (v.exp_err != 0) v.exp_frames = 0;
      else if (v.abort_frame > 0 && (v.cnt == 0 || v.abort_frame < v.cnt)) v.exp_frames = v.abort_frame;
      else v.exp_frames = v.cnt;
      exp_q.delete();
      for (int k = 0; k < v.exp_frames; k++) exp_q.push_back(model_len(v.mn, v.mx, v.st, k));
      run_sweep(v, 1'b1);
      check_run($sformatf("rnd%0d", r), v);
      reset_pulse();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
